// File: rtl/timer_compare_ctrl.sv
// Register-programmed compare unit for a 64-bit free-running timer: drives the
// timer enable/clear controls and raises sticky per-channel interrupts on compare matches.
module timer_compare_ctrl #(
  parameter int NUM_CH = 4
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              i_wr_en,
  input  logic [3:0]        i_wr_addr,
  input  logic [63:0]       i_wr_data,
  input  logic [63:0]       i_timer_value,
  output logic [7:0]        o_timer_ctrl,
  output logic [NUM_CH-1:0] o_irq_pending,
  output logic              o_irq,
  output logic [NUM_CH-1:0] o_ch_active
);

  typedef enum logic {IDLE, ARMED} chState_t;

  chState_t          r_state [NUM_CH];
  logic [63:0]       r_period [NUM_CH];
  logic [63:0]       r_target [NUM_CH];
  logic [NUM_CH-1:0] r_periodic;
  logic [NUM_CH-1:0] r_pending;
  logic              r_enable;
  logic              r_clear;

  logic              w_cmdWr;
  logic              w_clearCmd;
  logic [NUM_CH-1:0] w_ack;
  logic [NUM_CH-1:0] w_fire;

  assign w_cmdWr    = i_wr_en && (i_wr_addr == 4'h0);
  assign w_clearCmd = w_cmdWr && i_wr_data[1];
  assign w_ack      = (i_wr_en && (i_wr_addr == 4'hF)) ? i_wr_data[NUM_CH-1:0] : '0;

  // A clear command idles every channel on its write edge, so it also suppresses any match there.
  always_comb begin
    w_fire = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_fire[i] = (r_state[i] == ARMED) && (i_timer_value == r_target[i]) && !w_clearCmd;
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_enable   <= 1'b0;
      r_clear    <= 1'b0;
      r_pending  <= '0;
      r_periodic <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i]  <= IDLE;
        r_period[i] <= '0;
        r_target[i] <= '0;
      end
    end else begin
      if (w_cmdWr) begin
        r_enable <= i_wr_data[0];
        r_clear  <= i_wr_data[1];
      end else begin
        r_clear  <= 1'b0;
      end
      // Set beats acknowledge when both hit the same channel on one edge.
      r_pending <= (r_pending & ~w_ack) | w_fire;
      for (int i = 0; i < NUM_CH; i++) begin
        if (i_wr_en && (i_wr_addr == 4'(i + 1))) begin
          r_period[i] <= i_wr_data;
        end
        if (w_clearCmd) begin
          r_state[i] <= IDLE;
        end else if (i_wr_en && (i_wr_addr == 4'(i + 8)) && i_wr_data[2]) begin
          r_state[i] <= IDLE;
        end else if (i_wr_en && (i_wr_addr == 4'(i + 8)) && i_wr_data[0] && (r_period[i] != 64'd0)) begin
          r_state[i]    <= ARMED;
          r_target[i]   <= i_timer_value + r_period[i];
          r_periodic[i] <= i_wr_data[1];
        end else if (w_fire[i]) begin
          if (r_periodic[i]) begin
            r_target[i] <= r_target[i] + r_period[i];
          end else begin
            r_state[i]  <= IDLE;
          end
        end
      end
    end
  end

  always_comb begin
    o_ch_active = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      o_ch_active[i] = (r_state[i] == ARMED);
    end
  end

  assign o_timer_ctrl  = {6'b0, r_clear, r_enable};
  assign o_irq_pending = r_pending;
  assign o_irq         = |r_pending;

endmodule
